wb_master_arbiter: RTL and testbench
====================================

Name: wb_master_arbiter

Overview:
- Two-master, one-slave-port Wishbone arbiter. It sits between the CPU (master 0) and a second bus master (master 1, e.g. a DMA or VGA refill engine) and the shared conbus slave-side fabric.
- Serialises single transfers with round-robin fairness.
- Guards every granted transfer with a watchdog: a slave that never acks cannot hang the multi-cycle CPU.

Parameters:
- DW, 32, data bus width
- AW, 32, address bus width
- SW, DW/8, number of byte-select lines
- TIMEOUT, 255, cycles a granted transfer may wait for ack before forced termination (1..65535)
- TO_DATA, 32'hDEAD_BEEF, read data returned on a timed-out transfer

Ports:
- clk_i  in  1  bus clock, single clock domain
- rst_i  in  1  reset; asynchronous, active-high
- m0_dat_i  in  DW  master 0 write data
- m0_adr_i  in  AW  master 0 address
- m0_sel_i  in  SW  master 0 byte selects
- m0_we_i  in  1  master 0 write enable
- m0_stb_i  in  1  master 0 request/strobe, held until ack
- m0_dat_o  out  DW  read data to master 0
- m0_ack_o  out  1  transfer done to master 0
- m1_dat_i, m1_adr_i, m1_sel_i, m1_we_i, m1_stb_i, m1_dat_o, m1_ack_o: same as m0_*, for master 1
- s_dat_o  out  DW  write data to fabric
- s_adr_o  out  AW  address to fabric
- s_sel_o  out  SW  byte selects to fabric
- s_we_o  out  1  write enable to fabric
- s_stb_o  out  1  strobe to fabric
- s_dat_i  in  DW  read data from fabric
- s_ack_i  in  1  ack from fabric
- gnt_o  out  2  one-hot current grant ({m1,m0}); 00 when idle
- timeout_o  out  1  one-cycle pulse on forced termination
- err_adr_o  out  AW  address of the most recent timed-out transfer

Behaviour:
- Reset (async): state IDLE; last-served pointer = 1, so m0 wins the first tie. All outputs 0: gnt_o, s_*, m*_ack_o, timeout_o, err_adr_o. m*_dat_o = 0. Watchdog counter = 0.
- FSM states: IDLE, GNT0, GNT1, DONE.
- IDLE:
  - Only one stb high: go to that master's GNT state.
  - Both high: grant the master that is not the last-served one.
  - Neither high: stay.
  - Decision is registered. The first s_stb_o appears 1 cycle after the stb is seen.
- GNTx:
  - s_adr_o/s_dat_o/s_sel_o/s_we_o = mx_* (combinational mux on the registered grant); s_stb_o = mx_stb_i.
  - mx_ack_o = s_ack_i & s_stb_o (combinational). Other master's ack_o = 0.
  - Both m*_dat_o = s_dat_i, except in the timeout case below.
- Ack seen in GNTx: next state DONE; last-served = x; watchdog cleared.
- DONE: one dead cycle with s_stb_o = 0, then IDLE. This guarantees the other master can win the next arbitration and that no back-to-back ack is double-counted.
- Abort: mx_stb_i drops before ack → IDLE next cycle, last-served = x, no ack issued.
- Watchdog:
  - Counts cycles spent in GNTx without ack.
  - When count == TIMEOUT and s_ack_i = 0: s_stb_o forced 0 that cycle; mx_ack_o = 1 for exactly one cycle with mx_dat_o = TO_DATA; timeout_o = 1; err_adr_o <= mx_adr_i; next state DONE.
  - Writes are dropped silently.
- s_ack_i and timeout in the same cycle: the real ack wins (normal completion, no timeout_o).
- Stray s_ack_i in IDLE/DONE: ignored, no master ack.
- rst_i mid-transfer: immediate return to IDLE with all outputs 0. An in-flight transfer is abandoned; the master must re-request.
- Grant never changes while in GNTx: no preemption, so the priority of a waiting master cannot be lost.

Decomposition:
- Shared package wb_arb_pkg holds:
  - state encodings ST_IDLE, ST_GNT0, ST_GNT1, ST_DONE
  - master index constants M0 = 0, M1 = 1
  - TO_DATA default
- One natural sub-module: wb_watchdog_ctr. Inputs: clk_i, rst_i, clr, en, limit. Output: expire. Width is $clog2(TIMEOUT+1).

Test Plan:
- Single m0 read: m0_stb_i = 1, adr = 0x0000_0010; slave acks 2 cycles after s_stb_o with s_dat_i = 0x1234_5678 → s_stb_o at cycle 1, m0_ack_o 1 cycle wide, m0_dat_o = 0x1234_5678, gnt_o = 01, then DONE and IDLE.
- Tie after reset: both stb high at cycle 0 → m0 granted first (gnt_o = 01); after its ack m1 is granted (gnt_o = 10). Repeated ties alternate 01/10/01.
- Continuous m0 requests with m1 pending: m1 served within 2 transfers; m0 never gets two consecutive grants while m1_stb_i = 1.
- Timeout: m1 write adr = 0xFFFF_FF00, slave never acks, TIMEOUT = 4 → m1_ack_o at cycle 4 of grant, m1_dat_o = 0xDEAD_BEEF, timeout_o one pulse, err_adr_o = 0xFFFF_FF00, s_stb_o = 0 in that cycle.
- Ack coincident with expiry: s_ack_i = 1 exactly at count == TIMEOUT → normal ack with s_dat_i data, timeout_o = 0, err_adr_o unchanged.
- Reset mid-grant: assert rst_i asynchronously while in GNT0 → gnt_o, s_stb_o and m0_ack_o go 0 immediately without a clock edge. After release with both stb high, m0 is granted.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared constants for the two-master Wishbone arbiter: FSM encodings,
// master indices, the timed-out read pattern and the round-robin pick.
package wb_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [31:0] TO_DATA_DEFAULT = 32'hDEAD_BEEF;

  // On a tie the master that was not served last wins.
  function automatic logic [1:0] rr_pick(input logic req0, input logic req1,
                                         input logic last);
    if (req0 && req1) return (last == M1) ? ST_GNT0 : ST_GNT1;
    else if (req0)    return ST_GNT0;
    else if (req1)    return ST_GNT1;
    else              return ST_IDLE;
  endfunction

endpackage

// File: rtl/wb_watchdog_ctr.sv
// Cycle counter bounding how long a granted transfer may wait for ack.
// Saturates at the limit so expire stays asserted until cleared.
module wb_watchdog_ctr #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: assigning a default before any branch keeps this block free of inferred latches.
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != limit))
      cnt_d = cnt_q + W'(1);
  end

  // NOTE: clocked state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire = en && (cnt_q == limit);

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin fairness and a
// per-transfer watchdog that completes a hung transfer with TO_DATA.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int              DW      = 32,
  parameter int              AW      = 32,
  parameter int              SW      = DW / 8,
  parameter int              TIMEOUT = 255,
  parameter logic [DW-1:0]   TO_DATA = DW'(TO_DATA_DEFAULT)
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic [DW-1:0] m0_dat_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_stb_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,

  input  logic [DW-1:0] m1_dat_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_stb_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,

  output logic [DW-1:0] s_dat_o,
  output logic [AW-1:0] s_adr_o,
  output logic [SW-1:0] s_sel_o,
  output logic          s_we_o,
  output logic          s_stb_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,

  output logic [1:0]    gnt_o,
  output logic          timeout_o,
  output logic [AW-1:0] err_adr_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [AW-1:0] err_adr_q, err_adr_d;

  logic          in_gnt0, in_gnt1, in_gnt, cur;
  logic          sel_stb, sel_we;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_dat;
  logic [SW-1:0] sel_sel;
  logic          expire, to_hit, done_ack, xfer_end;

  assign in_gnt0 = (state_q == ST_GNT0);
  assign in_gnt1 = (state_q == ST_GNT1);
  assign in_gnt  = in_gnt0 | in_gnt1;
  assign cur     = in_gnt1 ? M1 : M0;

  // Fabric side follows the registered grant; nothing is driven when idle.
  always_comb begin
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    sel_sel = '0;
    if (in_gnt0) begin
      sel_stb = m0_stb_i;
      sel_we  = m0_we_i;
      sel_adr = m0_adr_i;
      sel_dat = m0_dat_i;
      sel_sel = m0_sel_i;
    end else if (in_gnt1) begin
      sel_stb = m1_stb_i;
      sel_we  = m1_we_i;
      sel_adr = m1_adr_i;
      sel_dat = m1_dat_i;
      sel_sel = m1_sel_i;
    end
  end

  // A real ack arriving in the expiry cycle wins over the timeout.
  assign to_hit   = in_gnt & sel_stb & expire & ~s_ack_i;
  assign s_stb_o  = sel_stb & ~to_hit;
  assign done_ack = s_ack_i & s_stb_o;
  assign xfer_end = done_ack | to_hit;

  assign s_adr_o  = sel_adr;
  assign s_dat_o  = sel_dat;
  assign s_sel_o  = sel_sel;
  assign s_we_o   = sel_we;

  assign m0_ack_o = in_gnt0 & xfer_end;
  assign m1_ack_o = in_gnt1 & xfer_end;
  assign m0_dat_o = (in_gnt0 & to_hit) ? TO_DATA : (in_gnt ? s_dat_i : '0);
  assign m1_dat_o = (in_gnt1 & to_hit) ? TO_DATA : (in_gnt ? s_dat_i : '0);

  assign gnt_o     = {in_gnt1, in_gnt0};
  assign timeout_o = to_hit;
  assign err_adr_o = err_adr_q;

  wb_watchdog_ctr #(
    .W (CW)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (~in_gnt | xfer_end | ~sel_stb),
    .en     (in_gnt),
    .limit  (CW'(TIMEOUT)),
    .expire (expire)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    err_adr_d = err_adr_q;
    case (state_q)
      ST_IDLE: state_d = rr_pick(m0_stb_i, m1_stb_i, last_q);
      ST_GNT0, ST_GNT1: begin
        if (!sel_stb) begin
          state_d = ST_IDLE;
          last_d  = cur;
        end else if (xfer_end) begin
          state_d = ST_DONE;
          last_d  = cur;
          if (to_hit) err_adr_d = sel_adr;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Last-served resets to M1 so master 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      last_q    <= M1;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      err_adr_q <= err_adr_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed self-checking bench for wb_master_arbiter with TIMEOUT = 4.
module tb_wb_master_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_dat_i, m0_adr_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_we_i, m0_stb_i, m0_ack_o;
  logic [31:0] m1_dat_i, m1_adr_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_we_i, m1_stb_i, m1_ack_o;
  logic [31:0] s_dat_o, s_adr_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_stb_o, s_ack_i;
  logic [1:0]  gnt_o;
  logic        timeout_o;
  logic [31:0] err_adr_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  wb_master_arbiter #(
    .DW (32), .AW (32), .SW (4), .TIMEOUT (4), .TO_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .m0_dat_i (m0_dat_i), .m0_adr_i (m0_adr_i), .m0_sel_i (m0_sel_i),
    .m0_we_i (m0_we_i), .m0_stb_i (m0_stb_i), .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o),
    .m1_dat_i (m1_dat_i), .m1_adr_i (m1_adr_i), .m1_sel_i (m1_sel_i),
    .m1_we_i (m1_we_i), .m1_stb_i (m1_stb_i), .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o),
    .s_dat_o (s_dat_o), .s_adr_o (s_adr_o), .s_sel_o (s_sel_o), .s_we_o (s_we_o),
    .s_stb_o (s_stb_o), .s_dat_i (s_dat_i), .s_ack_i (s_ack_i),
    .gnt_o (gnt_o), .timeout_o (timeout_o), .err_adr_o (err_adr_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks follow 1 unit later.
  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  // Entered from an IDLE cycle with requests pending: grant, ack at once,
  // stray ack in DONE, back to IDLE.
  task automatic serve(input string tag, input logic [1:0] exp_gnt,
                       input logic [31:0] exp_adr, input logic [31:0] rdata);
    adv();
    s_ack_i = 1'b1;
    s_dat_i = rdata;
    #1;
    check({tag, " gnt"}, 32'(gnt_o), 32'(exp_gnt));
    check({tag, " adr"}, s_adr_o, exp_adr);
    check({tag, " acks"}, 32'({m1_ack_o, m0_ack_o}), 32'(exp_gnt));
    check({tag, " rdata"}, exp_gnt[1] ? m1_dat_o : m0_dat_o, rdata);
    adv();
    #1;
    check({tag, " done gnt"}, 32'(gnt_o), 32'd0);
    check({tag, " done stray ack"}, 32'({m1_ack_o, m0_ack_o}), 32'd0);
    check({tag, " done stb"}, 32'(s_stb_o), 32'd0);
    adv();
    s_ack_i = 1'b0;
    #1;
    check({tag, " idle gnt"}, 32'(gnt_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global time limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_i = 1'b1;
    m0_dat_i = '0; m0_adr_i = '0; m0_sel_i = 4'hF; m0_we_i = 1'b0; m0_stb_i = 1'b0;
    m1_dat_i = '0; m1_adr_i = '0; m1_sel_i = 4'hF; m1_we_i = 1'b0; m1_stb_i = 1'b0;
    s_dat_i = '0; s_ack_i = 1'b0;
    #12;
    check("rst gnt", 32'(gnt_o), 32'd0);
    check("rst s_stb", 32'(s_stb_o), 32'd0);
    check("rst timeout", 32'(timeout_o), 32'd0);
    check("rst err_adr", err_adr_o, 32'd0);
    check("rst m0_dat", m0_dat_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Single m0 read, ack two cycles after s_stb_o.
    adv();
    m0_adr_i = 32'h0000_0010; m0_stb_i = 1'b1;
    #1;
    check("rd c0 gnt", 32'(gnt_o), 32'd0);
    check("rd c0 s_stb", 32'(s_stb_o), 32'd0);
    adv(); #1;
    check("rd c1 gnt", 32'(gnt_o), 32'b01);
    check("rd c1 s_stb", 32'(s_stb_o), 32'd1);
    check("rd c1 s_adr", s_adr_o, 32'h0000_0010);
    check("rd c1 ack", 32'(m0_ack_o), 32'd0);
    adv(); #1;
    check("rd c2 s_stb", 32'(s_stb_o), 32'd1);
    check("rd c2 ack", 32'(m0_ack_o), 32'd0);
    adv();
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    #1;
    check("rd c3 ack", 32'(m0_ack_o), 32'd1);
    check("rd c3 m1_ack", 32'(m1_ack_o), 32'd0);
    check("rd c3 data", m0_dat_o, 32'h1234_5678);
    adv();
    s_ack_i = 1'b0; m0_stb_i = 1'b0;
    #1;
    check("rd c4 ack", 32'(m0_ack_o), 32'd0);
    check("rd c4 gnt", 32'(gnt_o), 32'd0);
    check("rd c4 s_stb", 32'(s_stb_o), 32'd0);
    adv(); #1;
    check("rd c5 gnt", 32'(gnt_o), 32'd0);

    // Fresh reset, then repeated ties alternate starting with m0.
    rst_i = 1'b1; #2; rst_i = 1'b0;
    adv();
    m0_adr_i = 32'h0000_0100; m1_adr_i = 32'h0000_0200;
    m0_stb_i = 1'b1; m1_stb_i = 1'b1;
    #1;
    check("tie c0 gnt", 32'(gnt_o), 32'd0);
    serve("tie0", 2'b01, 32'h0000_0100, 32'hA000_0001);
    serve("tie1", 2'b10, 32'h0000_0200, 32'hA000_0002);
    serve("tie2", 2'b01, 32'h0000_0100, 32'hA000_0003);
    m0_stb_i = 1'b0; m1_stb_i = 1'b0;

    // m1 abort: strobe drops while granted, no ack.
    adv();
    m1_stb_i = 1'b1;
    adv(); #1;
    check("abort gnt", 32'(gnt_o), 32'b10);
    m1_stb_i = 1'b0;
    #1;
    check("abort s_stb", 32'(s_stb_o), 32'd0);
    check("abort ack", 32'(m1_ack_o), 32'd0);
    adv(); #1;
    check("abort idle gnt", 32'(gnt_o), 32'd0);

    // m1 write to a slave that never acks.
    adv();
    m1_adr_i = 32'hFFFF_FF00; m1_we_i = 1'b1; m1_dat_i = 32'h0000_55AA; m1_stb_i = 1'b1;
    adv(); #1;
    check("to g0 gnt", 32'(gnt_o), 32'b10);
    check("to g0 we", 32'(s_we_o), 32'd1);
    check("to g0 wdata", s_dat_o, 32'h0000_55AA);
    for (int i = 1; i < 4; i++) begin
      adv(); #1;
      check("to wait s_stb", 32'(s_stb_o), 32'd1);
      check("to wait ack", 32'(m1_ack_o), 32'd0);
      check("to wait timeout", 32'(timeout_o), 32'd0);
    end
    adv(); #1;
    check("to hit s_stb", 32'(s_stb_o), 32'd0);
    check("to hit ack", 32'(m1_ack_o), 32'd1);
    check("to hit m0_ack", 32'(m0_ack_o), 32'd0);
    check("to hit data", m1_dat_o, 32'hDEAD_BEEF);
    check("to hit pulse", 32'(timeout_o), 32'd1);
    adv();
    m1_stb_i = 1'b0; m1_we_i = 1'b0;
    #1;
    check("to done pulse", 32'(timeout_o), 32'd0);
    check("to done ack", 32'(m1_ack_o), 32'd0);
    check("to done err_adr", err_adr_o, 32'hFFFF_FF00);
    adv();

    // m0 read with the slave acking exactly at expiry.
    adv();
    m0_adr_i = 32'h0000_0020; m0_stb_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) adv();
    adv();
    s_ack_i = 1'b1;
    #1;
    check("co ack", 32'(m0_ack_o), 32'd1);
    check("co data", m0_dat_o, 32'hCAFE_F00D);
    check("co timeout", 32'(timeout_o), 32'd0);
    check("co s_stb", 32'(s_stb_o), 32'd1);
    adv();
    s_ack_i = 1'b0; m0_stb_i = 1'b0;
    #1;
    check("co err_adr kept", err_adr_o, 32'hFFFF_FF00);
    check("co done timeout", 32'(timeout_o), 32'd0);
    adv();

    // Asynchronous reset in the middle of an m0 grant.
    adv();
    m0_stb_i = 1'b1;
    adv(); #1;
    check("ar pre gnt", 32'(gnt_o), 32'b01);
    #1;
    rst_i = 1'b1; s_ack_i = 1'b1;
    #1;
    check("ar gnt", 32'(gnt_o), 32'd0);
    check("ar s_stb", 32'(s_stb_o), 32'd0);
    check("ar ack", 32'(m0_ack_o), 32'd0);
    check("ar err_adr", err_adr_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; s_ack_i = 1'b0; m1_stb_i = 1'b1;
    adv(); #1;
    check("ar tie gnt", 32'(gnt_o), 32'b01);
    m0_stb_i = 1'b0; m1_stb_i = 1'b0;
    adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
